// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared loader/processor constants and FSM encoding
package program_loader_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/loader_counter.sv
// rtl/loader_counter.sv - saturating word counter that also supplies the write address
module loader_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W:0]   count,
  output logic [W-1:0] addr,
  output logic         terminal
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !count[W]) begin
      count <= count + 1'b1;
    end
  end

  // Once the memory is full the address pins at the top word instead of wrapping.
  assign addr     = count[W] ? {W{1'b1}} : count[W-1:0];
  assign terminal = (count[W-1:0] == {W{1'b1}}) && !count[W];

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program into instruction memory, then releases the processor
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              system_reset_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  // Assert asynchronously, release two clocks later so no flop sees a ragged deassertion.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  loader_state_t     state, next_state;
  logic              handshake;
  logic              cnt_clear;
  logic              cnt_inc;
  logic              set_error;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_terminal;

  loader_counter #(.W(ADDR_W)) u_counter (
    .clk      (clock),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .count    (word_count),
    .addr     (cnt_addr),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    handshake  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    set_error  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_LOAD;
          cnt_clear  = 1'b1;
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          handshake = 1'b1;
          cnt_inc   = 1'b1;
          if (s_last) begin
            next_state = ST_RUN;
          end else if (cnt_terminal) begin
            next_state = ST_DRAIN;
            set_error  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start) begin
          next_state = ST_LOAD;
          cnt_clear  = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= handshake;
      if (handshake) begin
        mem_addr  <= cnt_addr;
        mem_wdata <= s_data;
      end
    end
  end

  // Release the CPU only once RUN has been held a full cycle, i.e. after the last write lands.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cpu_reset <= !((state == ST_RUN) && (next_state == ST_RUN));
      done      <= (state == ST_RUN) && (next_state == ST_RUN);
      if (cnt_clear) begin
        error <= 1'b0;
      end else if (set_error) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clock = 1'b0;
  logic        system_reset_n;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [4:0]  word_count;

  int vecs = 0;
  int miss = 0;
  int we_cnt = 0;
  int we_base;

  program_loader #(.ADDR_W(4), .DATA_W(32)) dut (
    .clock          (clock),
    .system_reset_n (system_reset_n),
    .start          (start),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .cpu_reset      (cpu_reset),
    .done           (done),
    .error          (error),
    .word_count     (word_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_we === 1'b1) we_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last,
                           input logic expect_write, input logic [3:0] exp_addr);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    chk("s_ready_before_hs", s_ready, 1'b1);
    cyc();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("mem_we_after_hs", mem_we, expect_write);
    if (expect_write) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, d);
    end
  endtask

  initial begin
    system_reset_n = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    repeat (3) cyc();

    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 4'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_word_count", word_count, 5'd0);

    system_reset_n = 1'b1;
    repeat (4) cyc();
    chk("idle_no_ready", s_ready, 1'b0);

    // Basic 3-word load
    pulse_start();
    chk("load_ready", s_ready, 1'b1);
    chk("load_cpu_reset", cpu_reset, 1'b1);
    we_base = we_cnt;
    send_word(32'h11, 1'b0, 1'b1, 4'd0);
    send_word(32'h22, 1'b0, 1'b1, 4'd1);
    send_word(32'h33, 1'b1, 1'b1, 4'd2);
    chk("cpu_reset_during_last_write", cpu_reset, 1'b1);
    cyc();
    chk("basic_mem_we_low", mem_we, 1'b0);
    chk("basic_cpu_reset", cpu_reset, 1'b0);
    chk("basic_done", done, 1'b1);
    chk("basic_word_count", word_count, 5'd3);
    chk("basic_run_not_ready", s_ready, 1'b0);
    chk("basic_error", error, 1'b0);
    chk("basic_we_pulses", we_cnt - we_base, 3);

    // Reload from RUN with a single word
    pulse_start();
    chk("reload_cpu_reset", cpu_reset, 1'b1);
    chk("reload_done", done, 1'b0);
    chk("reload_ready", s_ready, 1'b1);
    we_base = we_cnt;
    send_word(32'hAB, 1'b1, 1'b1, 4'd0);
    cyc();
    chk("reload_word_count", word_count, 5'd1);
    chk("reload_done_again", done, 1'b1);
    chk("reload_cpu_run", cpu_reset, 1'b0);
    chk("reload_we_pulses", we_cnt - we_base, 1);

    // Gapped load: s_valid low two cycles between words
    pulse_start();
    we_base = we_cnt;
    send_word(32'h11, 1'b0, 1'b1, 4'd0);
    cyc(); chk("gap_we_0a", mem_we, 1'b0);
    cyc(); chk("gap_we_0b", mem_we, 1'b0);
    send_word(32'h22, 1'b0, 1'b1, 4'd1);
    cyc(); chk("gap_we_1a", mem_we, 1'b0);
    cyc(); chk("gap_we_1b", mem_we, 1'b0);
    send_word(32'h33, 1'b1, 1'b1, 4'd2);
    cyc();
    chk("gap_word_count", word_count, 5'd3);
    chk("gap_done", done, 1'b1);
    chk("gap_we_pulses", we_cnt - we_base, 3);

    // Overflow: 20 words into a 16-word memory
    pulse_start();
    we_base = we_cnt;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] a;
      a = i[3:0];
      send_word(32'h100 + i, (i == 19), (i < 16), a);
      if (i == 15) chk("ovf_error_set", error, 1'b1);
    end
    cyc();
    chk("ovf_cpu_reset", cpu_reset, 1'b1);
    chk("ovf_idle_not_ready", s_ready, 1'b0);
    chk("ovf_error_sticky", error, 1'b1);
    chk("ovf_done", done, 1'b0);
    chk("ovf_word_count", word_count, 5'd16);
    chk("ovf_last_addr", mem_addr, 4'd15);
    chk("ovf_we_pulses", we_cnt - we_base, 16);

    // Reset in the middle of a 4-word load
    pulse_start();
    chk("mid_error_cleared", error, 1'b0);
    send_word(32'h51, 1'b0, 1'b1, 4'd0);
    send_word(32'h52, 1'b0, 1'b1, 4'd1);
    we_base = we_cnt;
    s_valid = 1'b1;
    s_data  = 32'h53;
    system_reset_n = 1'b0;
    #1;
    chk("async_mem_we", mem_we, 1'b0);
    chk("async_mem_addr", mem_addr, 4'd0);
    chk("async_mem_wdata", mem_wdata, 32'd0);
    chk("async_cpu_reset", cpu_reset, 1'b1);
    chk("async_word_count", word_count, 5'd0);
    chk("async_s_ready", s_ready, 1'b0);
    repeat (3) cyc();
    system_reset_n = 1'b1;
    repeat (5) cyc();
    chk("post_rst_we_pulses", we_cnt - we_base, 0);
    chk("post_rst_not_ready", s_ready, 1'b0);
    chk("post_rst_cpu_reset", cpu_reset, 1'b1);
    s_valid = 1'b0;
    pulse_start();
    send_word(32'h99, 1'b1, 1'b1, 4'd0);
    cyc();
    chk("restart_word_count", word_count, 5'd1);
    chk("restart_done", done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
